// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

   // Loader session states
   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      DONE,
      ERR
   } ldr_state_e;

   // Bytes assembled into one instruction word
   localparam int unsigned BYTES_PER_WORD = 4;
   // Bytes in the word-count header
   localparam int unsigned HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian instruction word one byte lane at a time.
// word_asm shows the word including the byte being accepted this cycle,
// so the caller can capture a complete word on the same edge as the last byte.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_asm,
   output logic        word_full
);

   localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

   logic [31:0]      word;
   logic [IDX_W-1:0] byte_idx;

   // Merge the incoming byte into its lane and flag the last lane
   always_comb begin
      word_asm = word;
      word_asm[{byte_idx, 3'b000} +: 8] = byte_in;
      word_full = load && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
   end

   // Lane register and byte index; the index wraps naturally after the last lane
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word     <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         word     <= '0;
         byte_idx <= '0;
      end else if (load) begin
         word     <= word_asm;
         byte_idx <= byte_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Runtime instruction-memory loader: receives a length-prefixed byte stream,
// writes little-endian 32-bit words to consecutive addresses, and holds the
// core in reset until the whole image has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);
   localparam logic [LEN_W:0] CNT_ONE   = {{LEN_W{1'b0}}, 1'b1};

   ldr_state_e       state;
   ldr_state_e       state_nxt;
   logic [7:0]       len_lo;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] len_rx;
   logic [LEN_W:0]   word_cnt;
   logic             xfer;
   logic             len_bad;
   logic             last_word;
   logic             pk_load;
   logic             pk_clear;
   logic [31:0]      word_asm;
   logic             word_full;

   byte_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (pk_clear),
      .load      (pk_load),
      .byte_in   (rx_data),
      .word_asm  (word_asm),
      .word_full (word_full)
   );

   // Handshake qualifiers, header validation and end-of-image detection
   always_comb begin
      xfer      = rx_valid && rx_ready;
      len_rx    = LEN_W'({rx_data, len_lo});
      len_bad   = (len_rx == '0) || ({1'b0, len_rx} > MAX_WORDS);
      last_word = ((word_cnt + CNT_ONE) == {1'b0, len});
      pk_load   = xfer && (state == DATA);
      pk_clear  = (state == LEN_HI);
   end

   // Next-state decision; start is only honoured when no session is in flight
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LEN_LO;
         LEN_LO:  if (xfer) state_nxt = LEN_HI;
         LEN_HI:  if (xfer) state_nxt = len_bad ? ERR : DATA;
         DATA:    if (word_full) state_nxt = WRITE;
         WRITE:   state_nxt = last_word ? DONE : DATA;
         DONE:    if (start) state_nxt = LEN_LO;
         ERR:     if (start) state_nxt = LEN_LO;
         default: state_nxt = IDLE;
      endcase
   end

   // State, counters and registered outputs; outputs decode the next state so
   // they line up with the state register rather than lagging a cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         len_lo    <= '0;
         len       <= '0;
         word_cnt  <= '0;
         rx_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_nxt;
         rx_ready  <= (state_nxt inside {LEN_LO, LEN_HI, DATA});
         busy      <= (state_nxt inside {LEN_LO, LEN_HI, DATA, WRITE});
         mem_we    <= (state_nxt == WRITE);
         done      <= (state_nxt == DONE);
         error     <= (state_nxt == ERR);
         cpu_reset <= (state_nxt != DONE);

         if ((state == LEN_LO) && xfer) begin
            len_lo <= rx_data;
         end
         if ((state == LEN_HI) && xfer) begin
            len      <= len_rx;
            word_cnt <= '0;
         end
         if ((state == DATA) && word_full) begin
            mem_addr  <= word_cnt[ADDR_W-1:0];
            mem_wdata <= word_asm;
         end
         if ((state == WRITE) && !last_word) begin
            word_cnt <= word_cnt + CNT_ONE;
         end
      end
   end

endmodule
